// File: rtl/csa_acc_ctrl_if.sv
// Port bundle for the carry-save accumulation controller: job control,
// operand beat stream and resolved result stream.
interface csa_acc_ctrl_if #(
  parameter int W     = 16,
  parameter int CNT_W = 8
);
  localparam int ACC_W = W + CNT_W + 2;

  logic             start;
  logic [CNT_W-1:0] cfg_beats;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W-1:0]     in_c;
  logic [W-1:0]     in_d;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             busy;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that edge.
  modport master (
    output start, cfg_beats, in_valid, in_a, in_b, in_c, in_d, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, cfg_beats, in_valid, in_a, in_b, in_c, in_d, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/csa_acc_ctrl.sv
// Sums a job of 4-operand beats through two rows of 4:2 compressors into a
// redundant sum/carry accumulator, then resolves it with one carry-propagate add.
module csa_acc_ctrl #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  csa_acc_ctrl_if.slave     bus,
  output logic [1:0]        dbg_state
);
  localparam int ACC_W = W + CNT_W + 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc_s;
  logic [ACC_W-1:0] acc_c;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [ACC_W-1:0] out_data_q;

  logic [ACC_W-1:0] ext_a, ext_b, ext_c, ext_d;
  logic [ACC_W-1:0] s1, c1, s2, c2;
  logic             accept;

  // Returns {sum, carry}; the represented value is sum + 2*carry (mod 2^ACC_W).
  // The inter-bit carry chain only ripples one position, never further.
  function automatic logic [2*ACC_W-1:0] compress42(
    input logic [ACC_W-1:0] x1,
    input logic [ACC_W-1:0] x2,
    input logic [ACC_W-1:0] x3,
    input logic [ACC_W-1:0] x4
  );
    logic [ACC_W-1:0] t, co, ci, s, c;
    t  = x1 ^ x2 ^ x3;
    co = (x1 & x2) | (x1 & x3) | (x2 & x3);
    ci = {co[ACC_W-2:0], 1'b0};
    s  = t ^ x4 ^ ci;
    c  = (t & x4) | (t & ci) | (x4 & ci);
    return {s, c};
  endfunction

  always_comb begin
    ext_a = {{(ACC_W-W){bus.in_a[W-1]}}, bus.in_a};
    ext_b = {{(ACC_W-W){bus.in_b[W-1]}}, bus.in_b};
    ext_c = {{(ACC_W-W){bus.in_c[W-1]}}, bus.in_c};
    ext_d = {{(ACC_W-W){bus.in_d[W-1]}}, bus.in_d};
    {s1, c1} = compress42(ext_a, ext_b, ext_c, ext_d);
    {s2, c2} = compress42(s1, c1 << 1, acc_s, acc_c << 1);
  end

  assign accept = bus.in_valid & in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc_s       <= '0;
      acc_c       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc_s  <= '0;
            acc_c  <= '0;
            cnt    <= bus.cfg_beats;
            busy_q <= 1'b1;
            if (bus.cfg_beats != '0) begin
              state      <= ACC;
              in_ready_q <= 1'b1;
            end else begin
              state <= RESOLVE;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc_s <= s2;
            acc_c <= c2;
            cnt   <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state      <= RESOLVE;
              in_ready_q <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          out_data_q  <= acc_s + (acc_c << 1);
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign dbg_state     = state;
endmodule
